// File: rtl/router_pkg.sv
// Shared definitions for the router output-port reader: header layout, limits,
// default timing and the reader FSM state type.
package router_pkg;
  localparam int LEN_MSB        = 7;
  localparam int LEN_LSB        = 2;
  localparam int ADDR_MSB       = 1;
  localparam int MAX_PAYLOAD    = 63;
  localparam int DEF_READ_DELAY = 5;
  localparam int DEF_STALL_MAX  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } rd_state_e;
endpackage

// File: rtl/router_parity_acc.sv
// Byte-wide running XOR; clear wins over enable.
module router_parity_acc (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] result_o
);
  logic [7:0] acc_q;

  always_ff @(posedge clock) begin
    if (!resetn)     acc_q <= '0;
    else if (clr_i)  acc_q <= '0;
    else if (en_i)   acc_q <= acc_q ^ data_i;
  end

  assign result_o = acc_q;
endmodule

// File: rtl/router_dest_reader.sv
// Drains one router output port: header, payload, parity; checks address and parity.
// state | meaning
// IDLE  | no packet; waits for vld_out
// WAIT  | settle delay before the first read strobe
// READ  | issuing reads and capturing header/payload/parity
// DONE  | one-cycle completion with status
module router_dest_reader
  import router_pkg::*;
#(
  parameter logic [1:0] PORT_ID    = 2'd0,
  parameter int         READ_DELAY = DEF_READ_DELAY,
  parameter int         STALL_MAX  = DEF_STALL_MAX
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        soft_reset,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  output logic        read_enb,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        pkt_done,
  output logic [5:0]  pkt_len,
  output logic        parity_err,
  output logic        addr_err,
  output logic        pkt_abort,
  output logic [15:0] pkt_count
);
  localparam int LEN_W   = $clog2(MAX_PAYLOAD + 1);
  localparam int IDX_W   = $clog2(MAX_PAYLOAD + 3);
  localparam int STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [4:0]         DELAY_LOAD = 5'(READ_DELAY - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

  rd_state_e          state_q, state_d;
  logic [4:0]         delay_q, delay_d;
  logic [IDX_W-1:0]   issued_q, issued_d, cap_idx_q, cap_idx_d;
  logic               hdr_seen_q, hdr_seen_d;
  logic               cap_pend_q;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         addr_q, addr_d;
  logic               byte_valid_q, byte_valid_d;
  logic [7:0]         byte_data_q, byte_data_d;
  logic               pkt_done_q, pkt_done_d;
  logic               parity_err_q, parity_err_d;
  logic               addr_err_q, addr_err_d;
  logic               pkt_abort_q, pkt_abort_d;
  logic [15:0]        pkt_count_q, pkt_count_d;

  logic [IDX_W-1:0]   total;
  logic               rd_issue, capture, is_hdr, is_parity, is_payload;
  logic               xor_clr, xor_en;
  logic [7:0]         xor_val;

  // Until the header lands the length is unknown, so only header + one more read may go out.
  assign total      = hdr_seen_q ? IDX_W'(len_q) + IDX_W'(2) : IDX_W'(2);
  assign read_enb   = (state_q == READ) && (issued_q < total) && !soft_reset;
  assign rd_issue   = read_enb && vld_out;
  assign capture    = (state_q == READ) && cap_pend_q;
  assign is_hdr     = capture && !hdr_seen_q;
  assign is_parity  = capture && hdr_seen_q && (cap_idx_q == IDX_W'(len_q) + IDX_W'(1));
  assign is_payload = capture && hdr_seen_q && !is_parity;
  assign xor_clr    = (state_q != READ);
  assign xor_en     = is_hdr || is_payload;

  router_parity_acc u_parity_acc (
    .clock    (clock),
    .resetn   (resetn),
    .clr_i    (xor_clr),
    .en_i     (xor_en),
    .data_i   (data_out),
    .result_o (xor_val)
  );

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    issued_d     = issued_q;
    cap_idx_d    = cap_idx_q;
    hdr_seen_d   = hdr_seen_q;
    stall_d      = stall_q;
    len_d        = len_q;
    addr_d       = addr_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    pkt_done_d   = 1'b0;
    parity_err_d = 1'b0;
    addr_err_d   = 1'b0;
    pkt_abort_d  = 1'b0;
    pkt_count_d  = pkt_count_q;

    if (state_q != READ) begin
      issued_d   = '0;
      cap_idx_d  = '0;
      hdr_seen_d = 1'b0;
      stall_d    = '0;
    end

    case (state_q)
      IDLE: begin
        if (vld_out && !soft_reset) begin
          if (READ_DELAY == 0) begin
            state_d = READ;
          end else begin
            state_d = WAIT;
            delay_d = DELAY_LOAD;
          end
        end
      end
      WAIT: begin
        if (soft_reset) begin
          state_d     = IDLE;
          pkt_abort_d = 1'b1;
        end else if (delay_q == 5'd0) begin
          state_d = READ;
        end else begin
          delay_d = delay_q - 1'b1;
        end
      end
      READ: begin
        if (rd_issue) begin
          issued_d = issued_q + 1'b1;
          stall_d  = '0;
        end else if (read_enb) begin
          stall_d = stall_q + 1'b1;
        end
        if (capture) cap_idx_d = cap_idx_q + 1'b1;
        if (is_hdr) begin
          len_d      = data_out[LEN_MSB:LEN_LSB];
          addr_d     = data_out[ADDR_MSB:0];
          hdr_seen_d = 1'b1;
        end
        if (is_payload) begin
          byte_valid_d = 1'b1;
          byte_data_d  = data_out;
        end
        if (soft_reset) begin
          state_d      = IDLE;
          pkt_abort_d  = 1'b1;
          byte_valid_d = 1'b0;
          byte_data_d  = byte_data_q;
        end else if (is_parity) begin
          state_d      = DONE;
          pkt_done_d   = 1'b1;
          parity_err_d = (xor_val != data_out);
          addr_err_d   = (addr_q != PORT_ID);
          pkt_count_d  = pkt_count_q + 16'd1;
        end else if (read_enb && !vld_out && (stall_q == STALL_LAST)) begin
          state_d     = IDLE;
          pkt_abort_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      delay_q      <= '0;
      issued_q     <= '0;
      cap_idx_q    <= '0;
      hdr_seen_q   <= 1'b0;
      cap_pend_q   <= 1'b0;
      stall_q      <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pkt_abort_q  <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      issued_q     <= issued_d;
      cap_idx_q    <= cap_idx_d;
      hdr_seen_q   <= hdr_seen_d;
      cap_pend_q   <= rd_issue;
      stall_q      <= stall_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      pkt_done_q   <= pkt_done_d;
      parity_err_q <= parity_err_d;
      addr_err_q   <= addr_err_d;
      pkt_abort_q  <= pkt_abort_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_len    = len_q;
  assign parity_err = parity_err_q;
  assign addr_err   = addr_err_q;
  assign pkt_abort  = pkt_abort_q;
  assign pkt_count  = pkt_count_q;
endmodule

// File: tb/tb_router_dest_reader.sv
// Scoreboard bench for router_dest_reader with a behavioural router FIFO in front of it.
module tb_router_dest_reader;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        soft_reset = 1'b0;
  logic        vld_out = 1'b0;
  logic [7:0]  data_out = 8'h00;
  logic        read_enb, byte_valid, pkt_done, parity_err, addr_err, pkt_abort;
  logic [7:0]  byte_data;
  logic [5:0]  pkt_len;
  logic [15:0] pkt_count;

  logic        vld28 = 1'b0;
  logic        read_enb28, byte_valid28, pkt_done28, parity_err28, addr_err28, pkt_abort28;
  logic [7:0]  byte_data28;
  logic [5:0]  pkt_len28;
  logic [15:0] pkt_count28;

  router_dest_reader dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .vld_out(vld_out),
    .data_out(data_out), .read_enb(read_enb), .byte_valid(byte_valid),
    .byte_data(byte_data), .pkt_done(pkt_done), .pkt_len(pkt_len),
    .parity_err(parity_err), .addr_err(addr_err), .pkt_abort(pkt_abort),
    .pkt_count(pkt_count)
  );

  router_dest_reader #(.READ_DELAY(28)) dut28 (
    .clock(clock), .resetn(resetn), .soft_reset(1'b0), .vld_out(vld28),
    .data_out(8'h00), .read_enb(read_enb28), .byte_valid(byte_valid28),
    .byte_data(byte_data28), .pkt_done(pkt_done28), .pkt_len(pkt_len28),
    .parity_err(parity_err28), .addr_err(addr_err28), .pkt_abort(pkt_abort28),
    .pkt_count(pkt_count28)
  );

  always #5 clock = ~clock;

  logic [7:0] fifo[$];
  logic [7:0] exp_bytes[$];
  logic [1:0] exp_done[$];
  logic hold = 1'b0, sr = 1'b0, rstn_v = 1'b0, v28 = 1'b0, rd_pend = 1'b0;
  int n_total = 0, n_bad = 0;
  int rd_cnt = 0, bv_cnt = 0, done_cnt = 0, abort_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs at the falling edge, then observe settled outputs.
  task automatic cyc();
    logic [1:0] e;
    @(negedge clock);
    if (rd_pend && fifo.size() != 0) data_out = fifo.pop_front();
    resetn     = rstn_v;
    soft_reset = sr;
    vld_out    = (fifo.size() != 0) && !hold;
    vld28      = v28;
    #1;
    rd_pend = read_enb && vld_out;
    if (rd_pend) rd_cnt++;
    if (byte_valid) begin
      bv_cnt++;
      if (exp_bytes.size() == 0) chk("byte_extra", 32'd1, 32'd0);
      else chk("byte", {24'd0, byte_data}, {24'd0, exp_bytes.pop_front()});
    end
    if (pkt_done) begin
      done_cnt++;
      if (exp_done.size() == 0) chk("done_extra", 32'd1, 32'd0);
      else begin
        e = exp_done.pop_front();
        chk("parity_err", {31'd0, parity_err}, {31'd0, e[1]});
        chk("addr_err", {31'd0, addr_err}, {31'd0, e[0]});
      end
    end
    if (pkt_abort) abort_cnt++;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] base, input logic [7:0] step,
                          input logic [7:0] flip, input bit want_done);
    logic [7:0] x, b;
    int n;
    n = int'(hdr[7:2]);
    x = hdr;
    fifo.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i) * step;
      x = x ^ b;
      fifo.push_back(b);
      exp_bytes.push_back(b);
    end
    fifo.push_back(x ^ flip);
    if (want_done) exp_done.push_back({flip != 8'h00, hdr[1:0] != 2'd0});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start, i;
    start = done_cnt;
    i = 0;
    while (done_cnt == start && i < budget) begin cyc(); i++; end
    if (done_cnt == start) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int target, input int budget);
    int i;
    i = 0;
    while (bv_cnt < target && i < budget) begin cyc(); i++; end
    if (bv_cnt < target) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic flush();
    fifo.delete();
    exp_bytes.delete();
    exp_done.delete();
  endtask

  initial begin
    int c0, b0, a0, i, lat;
    rstn_v = 1'b0;
    repeat (3) cyc();
    chk("rst_read_enb", {31'd0, read_enb}, 32'd0);
    chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    chk("rst_pkt_abort", {31'd0, pkt_abort}, 32'd0);
    chk("rst_errs", {30'd0, parity_err, addr_err}, 32'd0);
    chk("rst_byte_data", {24'd0, byte_data}, 32'd0);
    chk("rst_pkt_len", {26'd0, pkt_len}, 32'd0);
    chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    rstn_v = 1'b1;
    repeat (2) cyc();

    // good 3-byte packet
    b0 = bv_cnt;
    send_pkt(8'h0C, 8'h11, 8'h11, 8'h00, 1'b1);
    wait_done("pktA", 100);
    chk("pktA_bytes", 32'(bv_cnt - b0), 32'd3);
    chk("pktA_count", {16'd0, pkt_count}, 32'd1);
    chk("pktA_len", {26'd0, pkt_len}, 32'd3);
    repeat (3) cyc();

    // parity corrupted
    send_pkt(8'h0C, 8'h11, 8'h11, 8'h01, 1'b1);
    wait_done("pktB", 100);
    chk("pktB_count", {16'd0, pkt_count}, 32'd2);
    repeat (3) cyc();

    // zero-length packet to the wrong address
    c0 = rd_cnt; b0 = bv_cnt;
    send_pkt(8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
    wait_done("pktC", 100);
    repeat (3) cyc();
    chk("pktC_reads", 32'(rd_cnt - c0), 32'd2);
    chk("pktC_bytes", 32'(bv_cnt - b0), 32'd0);
    chk("pktC_len", {26'd0, pkt_len}, 32'd0);
    chk("pktC_count", {16'd0, pkt_count}, 32'd3);

    // 10-cycle source stall after the second payload byte
    b0 = bv_cnt;
    send_pkt(8'h14, 8'hA0, 8'h01, 8'h00, 1'b1);
    wait_bytes("stall10", b0 + 2, 100);
    hold = 1'b1;
    repeat (10) cyc();
    hold = 1'b0;
    wait_done("stall10", 100);
    chk("stall10_bytes", 32'(bv_cnt - b0), 32'd5);
    chk("stall10_count", {16'd0, pkt_count}, 32'd4);
    repeat (3) cyc();

    // 70-cycle stall: must abort
    b0 = bv_cnt; a0 = abort_cnt; c0 = done_cnt;
    send_pkt(8'h14, 8'h50, 8'h03, 8'h00, 1'b0);
    wait_bytes("stall64", b0 + 2, 100);
    hold = 1'b1;
    repeat (70) cyc();
    chk("stall64_abort", 32'(abort_cnt - a0), 32'd1);
    chk("stall64_done", 32'(done_cnt - c0), 32'd0);
    chk("stall64_count", {16'd0, pkt_count}, 32'd4);
    chk("stall64_read_enb", {31'd0, read_enb}, 32'd0);
    flush();
    hold = 1'b0;
    repeat (3) cyc();

    // soft reset just after the header lands
    a0 = abort_cnt; c0 = done_cnt;
    send_pkt(8'h0C, 8'h31, 8'h02, 8'h00, 1'b0);
    i = 0;
    while (pkt_len != 6'd3 && i < 100) begin cyc(); i++; end
    if (pkt_len != 6'd3) chk("sr_hdr_timeout", 32'd0, 32'd1);
    sr = 1'b1;
    cyc();
    sr = 1'b0;
    fifo.delete();
    cyc();
    chk("sr_abort", {31'd0, pkt_abort}, 32'd1);
    chk("sr_read_enb", {31'd0, read_enb}, 32'd0);
    exp_bytes.delete();
    b0 = bv_cnt;
    repeat (15) cyc();
    chk("sr_no_done", 32'(done_cnt - c0), 32'd0);
    chk("sr_no_bytes", 32'(bv_cnt - b0), 32'd0);
    chk("sr_abort_once", 32'(abort_cnt - a0), 32'd1);

    // synchronous reset mid-packet, with soft_reset asserted alongside
    b0 = bv_cnt;
    send_pkt(8'h14, 8'h70, 8'h01, 8'h00, 1'b0);
    wait_bytes("rstmid", b0 + 1, 100);
    rstn_v = 1'b0; sr = 1'b1;
    cyc();
    cyc();
    chk("rstmid_read_enb", {31'd0, read_enb}, 32'd0);
    chk("rstmid_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("rstmid_pkt_abort", {31'd0, pkt_abort}, 32'd0);
    chk("rstmid_byte_data", {24'd0, byte_data}, 32'd0);
    chk("rstmid_pkt_len", {26'd0, pkt_len}, 32'd0);
    chk("rstmid_pkt_count", {16'd0, pkt_count}, 32'd0);
    flush();
    sr = 1'b0; rstn_v = 1'b1;
    repeat (3) cyc();

    // READ_DELAY=28 instance: first strobe 29 cycles after vld_out is seen
    v28 = 1'b1;
    cyc();
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      cyc();
      if (read_enb28) lat = k;
    end
    v28 = 1'b0;
    chk("rd28_window", {31'd0, (lat > 0 && lat <= 29)}, 32'd1);
    chk("rd28_latency", 32'(lat), 32'd29);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/router_dest_reader.md
ROUTER_DEST_READER -- requirements
Module: router_dest_reader

Interface
REQ-001 Parameter: PORT_ID, default 2'd0, the address this output port serves; headers with any other address set addr_err.
REQ-002 Parameter: READ_DELAY, default 5, idle cycles between seeing vld_out and the first read_enb; legal range 0..28 so the router's 30-cycle soft-reset window is never hit.
REQ-003 Parameter: STALL_MAX, default 64, mid-packet cycles with vld_out low before the packet is aborted.
REQ-004 clock  in  1  clock; all logic on posedge clock.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 soft_reset  in  1  router per-port soft reset; flushes the FIFO feeding this reader.
REQ-007 vld_out  in  1  router port has data (FIFO not empty).
REQ-008 data_out  in  8  router FIFO read data; valid the cycle after a read_enb accepted while vld_out=1.
REQ-009 read_enb  out  1  read strobe to the router FIFO.
REQ-010 byte_valid  out  1  one-cycle strobe, payload byte on byte_data.
REQ-011 byte_data  out  8  captured payload byte.
REQ-012 pkt_done  out  1  one-cycle pulse after the parity byte is captured.
REQ-013 pkt_len  out  6  payload length of the last header; held until the next header.
REQ-014 parity_err  out  1  valid with pkt_done; received parity differs from the computed parity.
REQ-015 addr_err  out  1  valid with pkt_done; header address differs from PORT_ID.
REQ-016 pkt_abort  out  1  one-cycle pulse when a packet is abandoned.
REQ-017 pkt_count  out  16  completed packets; wraps at 16'hFFFF to 0.

Function
REQ-018 Packet format: header {len[7:2], addr[1:0]}, then len payload bytes (0..63), then a parity byte equal to the XOR of the header and all payload bytes.
REQ-019 FSM states: IDLE, WAIT, READ, DONE.
  - IDLE -> WAIT when vld_out=1.
  - WAIT -> READ after READ_DELAY cycles (READ_DELAY=0 goes straight to READ).
  - READ -> DONE when the parity byte is captured.
  - DONE -> IDLE after one cycle.
REQ-020 read_enb shall be 1 only in READ, while issued reads < total, where total = 2 before the header is captured and len+2 after.
REQ-021 A read is issued in a cycle iff read_enb=1 and vld_out=1.
REQ-022 A byte is captured one cycle after each issued read.
  - Byte index 0 is the header.
  - Indices 1..len are payload.
  - Index len+1 is the parity byte.
REQ-023 Payload bytes drive byte_valid=1 and byte_data in the capture cycle, i.e. two-cycle latency from read_enb to byte_valid.
REQ-024 The running XOR shall include the header and payload; parity_err=(xor != parity byte).
REQ-025 pkt_done, parity_err and addr_err are asserted in DONE; pkt_count increments in the same cycle.
REQ-026 len=0: exactly two reads are issued, no byte_valid occurs, and pkt_done follows the parity byte.
REQ-027 vld_out low in READ: read_enb stays asserted, no byte is captured, and the stall counter increments; any issued read clears it.
REQ-028 Stall counter reaching STALL_MAX: pkt_abort pulses and the FSM returns to IDLE; pkt_count is unchanged.
REQ-029 soft_reset=1 in WAIT or READ: pkt_abort pulses, the FSM returns to IDLE next cycle, read_enb drops, and any in-flight capture is discarded.
REQ-030 soft_reset=1 in IDLE or DONE: no pulse; DONE completes normally.
REQ-031 A back-to-back packet (vld_out still 1 in DONE) re-enters WAIT through IDLE; the minimum inter-packet gap is READ_DELAY+2 cycles.

Reset
REQ-032 resetn=0 shall force on the next clock edge:
  - FSM to IDLE.
  - read_enb, byte_valid, pkt_done, parity_err, addr_err, pkt_abort to 0.
  - byte_data, pkt_len, pkt_count to 0.
  - All counters and the XOR accumulator to 0.
REQ-033 resetn takes priority over soft_reset and over all other inputs.

Structure
REQ-034 Shared package router_pkg: header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1), MAX_PAYLOAD=63, the FSM state type, and the default READ_DELAY/STALL_MAX values.
REQ-035 One sub-module, router_parity_acc: byte-wide XOR accumulator with clear, enable and data inputs and an 8-bit result, instantiated once.

Verification
REQ-036 Header 8'h0C (len 3, addr 0), payload 11,22,33, parity 8'h0C^11^22^33 -> three byte_valid strobes in order, pkt_done=1, parity_err=0, addr_err=0, pkt_count=1.
REQ-037 Same packet with the parity byte XORed with 8'h01 -> pkt_done=1, parity_err=1.
REQ-038 Header 8'h01 (len 0, addr 1), PORT_ID=0 -> exactly 2 read strobes, no byte_valid, addr_err=1.
REQ-039 vld_out dropped for 10 cycles after the 2nd payload byte of a len-5 packet, then resumed -> 5 bytes delivered and pkt_done; vld_out held low 64 cycles instead -> pkt_abort, FSM in IDLE, pkt_count unchanged.
REQ-040 soft_reset pulsed in the cycle after the header is captured -> pkt_abort next cycle, read_enb=0, no pkt_done.
REQ-041 READ_DELAY=28, vld_out rising at cycle T -> first read_enb at T+29 or earlier, never beyond the 30-cycle window; resetn=0 mid-packet -> all outputs at reset values the next cycle.
